// File: rtl/pack_fifo_pkg.sv
// Shared types and helpers for the pack_fifo width-converting FIFO.
package pack_fifo_pkg;

  localparam int MAX_RATIO = 64;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Pointer width carries one extra wrap bit beyond the address bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Low n bits set, oldest-word-first lane order.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned n);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pack_fifo_if.sv
// Narrow-in / wide-out handshake bundle for pack_fifo.
interface pack_fifo_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  // Both sides: a transfer happens on a clock edge where valid && ready.
  // valid may not depend on ready; data/keep are stable while valid is held.
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]      out_keep;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );
endinterface

// File: rtl/pack_fifo_mem.sv
// DEPTH x IN_W storage: one write port, RATIO consecutive words read combinationally.
module pack_fifo_mem
  import pack_fifo_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [IN_W-1:0]            wdata,
  input  logic [AW-1:0]              raddr,
  output logic [RATIO-1:0][IN_W-1:0] rdata
);

  logic [IN_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Address arithmetic wraps at DEPTH, so a read may start at any offset.
  for (genvar k = 0; k < RATIO; k++) begin : g_rd
    assign rdata[k] = mem[raddr + AW'(k)];
  end

endmodule

// File: rtl/pack_fifo.sv
// Width-converting FIFO packing RATIO narrow words per wide output word.
// Optional flush of a trailing partial word is built when PACK_FIFO_FLUSH_EN is defined.
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 0,
  localparam int PTR_W    = ptr_w(DEPTH),
  localparam int AW       = PTR_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  pack_fifo_if.slave       bus,
  input  logic             flush,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty,
  output state_t           dbg_state
);

  localparam logic [PTR_W-1:0] RATIO_C = PTR_W'(RATIO);
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);

  state_t                    state_q;
  logic [PTR_W-1:0]          wptr_q, rptr_q;
  logic [PTR_W-1:0]          rd_adv;
  logic                      partial, wr_fire, rd_fire;
  logic [RATIO-1:0]          keep_ord;
  logic [RATIO-1:0][IN_W-1:0] rd_words;

  // Status comes straight from the pointer flops, so it has no input dependence.
  assign count     = wptr_q - rptr_q;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign dbg_state = state_q;

`ifdef PACK_FIFO_FLUSH_EN
  assign partial  = (state_q == ST_FLUSH) && (count != '0) && (count < RATIO_C);
  assign keep_ord = partial ? RATIO'(keep_mask(32'(count))) : {RATIO{bus.out_valid}};
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign partial      = 1'b0;
  assign keep_ord     = {RATIO{bus.out_valid}};
`endif

  assign bus.in_ready  = !full && (state_q == ST_RUN);
  assign bus.out_valid = (count >= RATIO_C) || partial;
  assign wr_fire       = bus.in_valid && bus.in_ready;
  assign rd_fire       = bus.out_valid && bus.out_ready;
  assign rd_adv        = !rd_fire ? '0 : (partial ? count : RATIO_C);

  pack_fifo_mem #(
    .IN_W  (IN_W),
    .RATIO (RATIO),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_words)
  );

  // Unkept lanes (including everything while out_valid is low) read as zero.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    localparam int LANE = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
    assign bus.out_keep[LANE]              = keep_ord[k];
    assign bus.out_data[LANE*IN_W +: IN_W] = keep_ord[k] ? rd_words[k] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= ST_RUN;
    end else begin
      wptr_q <= wptr_q + PTR_W'(wr_fire);
      rptr_q <= rptr_q + rd_adv;
`ifdef PACK_FIFO_FLUSH_EN
      case (state_q)
        ST_RUN: begin
          if (flush && (count != '0)) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if ((count == '0) || (rd_fire && partial)) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
`else
      state_q <= ST_RUN;
`endif
    end
  end

endmodule

// File: tb/tb_pack_fifo.sv
// Directed self-checking bench for pack_fifo: LSB-first and MSB-first instances driven in lockstep.
module tb_pack_fifo;
  import pack_fifo_pkg::*;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            in_valid, out_ready, flush;
  logic [IN_W-1:0] in_data;

  pack_fifo_if #(.IN_W(IN_W), .RATIO(RATIO)) bus0 ();
  pack_fifo_if #(.IN_W(IN_W), .RATIO(RATIO)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  logic [CW-1:0] count0, count1;
  logic          full0, full1, empty0, empty1;
  state_t        st0, st1;

  pack_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .flush(flush),
    .count(count0), .full(full0), .empty(empty0), .dbg_state(st0)
  );

  pack_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .flush(flush),
    .count(count1), .full(full1), .empty(empty1), .dbg_state(st1)
  );

  // Scoreboard
  int              n_cmp = 0;
  int              n_err = 0;
  logic [IN_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IN_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count0), 32'd0);
    chk({tag, "_empty"}, 32'(empty0), 32'd1);
    chk({tag, "_full"}, 32'(full0), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus0.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, "_out_data"}, bus0.out_data, 32'h0);
    chk({tag, "_out_keep"}, 32'(bus0.out_keep), 32'h0);
    chk({tag, "_state"}, 32'(st0), 32'(ST_RUN));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int words;
    logic [31:0] exp_w;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk_reset_state("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic packing in both lane orders
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("pack_valid", 32'(bus0.out_valid), 32'd1);
    chk("pack_lsb_data", bus0.out_data, 32'h44332211);
    chk("pack_keep", 32'(bus0.out_keep), 32'hF);
    chk("pack_msb_data", bus1.out_data, 32'h11223344);
    chk("pack_count", 32'(count0), 32'd4);
    tick();
    chk("pack_drained_count", 32'(count0), 32'd0);
    chk("pack_drained_valid", 32'(bus0.out_valid), 32'd0);

    // Fill to full with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    chk("full_flag", 32'(full0), 32'd1);
    chk("full_in_ready", 32'(bus0.in_ready), 32'd0);
    chk("full_count", 32'(count0), 32'd16);
    push(8'hEE);
    chk("full_reject_count", 32'(count0), 32'd16);
    chk("full_head_word", bus0.out_data, 32'h53525150);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_read_count", 32'(count0), 32'd12);
    chk("one_read_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("drain_w1", bus0.out_data, 32'h57565554);
    out_ready = 1'b1; tick();
    chk("drain_w2", bus0.out_data, 32'h5B5A5958);
    tick();
    chk("drain_w3", bus0.out_data, 32'h5F5E5D5C);
    tick();
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_valid", 32'(bus0.out_valid), 32'd0);

    // Streaming across three pointer wraps
    words = 0;
    for (int cyc = 0; cyc < 54; cyc++) begin
      if (bus0.out_valid) begin
        if (exp_q.size() < 4) begin
          chk("wrap_underrun", 32'(exp_q.size()), 32'd4);
        end else begin
          exp_w[7:0]   = exp_q.pop_front();
          exp_w[15:8]  = exp_q.pop_front();
          exp_w[23:16] = exp_q.pop_front();
          exp_w[31:24] = exp_q.pop_front();
          chk("wrap_word", bus0.out_data, exp_w);
          words++;
        end
      end
      if (cyc < 48) begin
        in_valid = 1'b1;
        in_data  = 8'(cyc * 7 + 3);
        exp_q.push_back(in_data);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_words", 32'(words), 32'd12);
    chk("wrap_leftover", 32'(exp_q.size()), 32'd0);
    chk("wrap_empty", 32'(empty0), 32'd1);

    // Flush of a two-word residue
    out_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    pulse_flush();
`ifdef PACK_FIFO_FLUSH_EN
    chk("flush_state", 32'(st0), 32'(ST_FLUSH));
    chk("flush_valid", 32'(bus0.out_valid), 32'd1);
    chk("flush_lsb_data", bus0.out_data, 32'h0000BBAA);
    chk("flush_lsb_keep", 32'(bus0.out_keep), 32'h3);
    chk("flush_msb_data", bus1.out_data, 32'hAABB0000);
    chk("flush_msb_keep", 32'(bus1.out_keep), 32'hC);
    chk("flush_in_ready", 32'(bus0.in_ready), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("flush_done_count", 32'(count0), 32'd0);
    chk("flush_done_state", 32'(st0), 32'(ST_RUN));
    chk("flush_done_valid", 32'(bus0.out_valid), 32'd0);
    push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
    chk("post_flush_data", bus0.out_data, 32'hFFEEDDCC);
`else
    chk("noflush_valid", 32'(bus0.out_valid), 32'd0);
    chk("noflush_count", 32'(count0), 32'd2);
    chk("noflush_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("noflush_keep", 32'(bus0.out_keep), 32'h0);
    push(8'hCC); push(8'hDD);
    chk("noflush_data", bus0.out_data, 32'hDDCCBBAA);
`endif
    chk("post_flush_keep", 32'(bus0.out_keep), 32'hF);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("post_flush_empty", 32'(empty0), 32'd1);

    // Asynchronous reset in the middle of a flush
    push(8'h12); push(8'h34);
    pulse_flush();
`ifdef PACK_FIFO_FLUSH_EN
    chk("mid_flush_state", 32'(st0), 32'(ST_FLUSH));
`endif
    chk("mid_flush_count", 32'(count0), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("after_rst_data", bus0.out_data, 32'h04030201);
    chk("after_rst_count", 32'(count0), 32'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("after_rst_empty", 32'(empty0), 32'd1);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
